// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pkg
// Brief    : Shared opcodes, next-PC select encodings and bubble instruction
//            for the decode stage and its register file.
// Revision : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

  // Opcodes that the decode stage resolves itself
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  // Next-PC select handed back to fetch
  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10
  } pcsrc_e;

  // Bubble instruction: sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Sign-extend a 16-bit immediate to 32 bits
  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Brief    : Register file with two asynchronous read ports, one synchronous
//            write port, write-through bypass and $0 hardwired to zero.
// Revision : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);

  localparam int NREGS = 1 << REG_AW;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              w_wr_en;

  // Writes aimed at $0 are dropped so that location never holds data
  assign w_wr_en = we_i && (waddr_i != '0);

  // Storage: reset clears every entry and wins over a concurrent write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1: $0 reads zero, a same-cycle write to the address bypasses
  always_comb begin
    rd1_o = '0;
    if (ra1_i != '0) begin
      rd1_o = (w_wr_en && (waddr_i == ra1_i)) ? wdata_i : regs_q[ra1_i];
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rd2_o = '0;
    if (ra2_i != '0) begin
      rd2_o = (w_wr_en && (waddr_i == ra2_i)) ? wdata_i : regs_q[ra2_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : IF/ID pipeline register, register file, sign extension, early
//            branch compare and branch/jump target generation.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int          DATA_W    = 32,
  parameter int          REG_AW    = 5,
  parameter logic [31:0] NOP_INSTR = decode_stage_pkg::NOP_INSTR
) (
  input  logic              clkD,
  input  logic              rstD,
  input  logic [31:0]       instrF,
  input  logic [31:0]       PCPlus4F,
  input  logic              stallD,
  input  logic              ForwardAD,
  input  logic              ForwardBD,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic [DATA_W-1:0] ResultW,
  output logic [31:0]       instrD,
  output logic [31:0]       PCPlus4D,
  output logic              validD,
  output logic [DATA_W-1:0] RD1D,
  output logic [DATA_W-1:0] RD2D,
  output logic [31:0]       SignImmD,
  output logic [4:0]        RsD,
  output logic [4:0]        RtD,
  output logic [4:0]        RdD,
  output logic [1:0]        PCSrcD,
  output logic [31:0]       PCBranchD,
  output logic [31:0]       PCJumpD
);

  import decode_stage_pkg::*;

  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] w_op_a, w_op_b;
  logic              w_eq;
  pcsrc_e            w_pcsrc;

  // IF/ID register; reset outranks stall, flush and write-back
  always_ff @(posedge clkD) begin
    if (rstD) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // IF/ID next state: stall holds, a redirect squashes the wrong-path fetch
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!stallD) begin
      pc4_d = PCPlus4F;
      if (w_pcsrc != PC_SEQ) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else begin
        instr_d = instrF;
        valid_d = 1'b1;
      end
    end
  end

  register_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_register_file (
    .clk_i   (clkD),
    .rst_i   (rstD),
    .we_i    (RegWriteW),
    .waddr_i (WriteRegW),
    .wdata_i (ResultW),
    .ra1_i   (instr_q[25:21]),
    .ra2_i   (instr_q[20:16]),
    .rd1_o   (RD1D),
    .rd2_o   (RD2D)
  );

  assign instrD   = instr_q;
  assign PCPlus4D = pc4_q;
  assign validD   = valid_q;
  assign RsD      = instr_q[25:21];
  assign RtD      = instr_q[20:16];
  assign RdD      = instr_q[15:11];
  assign SignImmD = sign_ext16(instr_q[15:0]);

  // Targets are always computed; fetch only uses them when PCSrcD selects
  assign PCBranchD = pc4_q + {SignImmD[29:0], 2'b00};
  assign PCJumpD   = {pc4_q[31:28], instr_q[25:0], 2'b00};

  // Early compare with optional forwarding from the memory stage
  assign w_op_a = ForwardAD ? ALUOutM : RD1D;
  assign w_op_b = ForwardBD ? ALUOutM : RD2D;
  assign w_eq   = (w_op_a == w_op_b);

  // Next-PC select; a stalled or bubbled slot never redirects
  always_comb begin
    w_pcsrc = PC_SEQ;
    if (valid_q && !stallD && !rstD) begin
      unique case (instr_q[31:26])
        OP_J:    w_pcsrc = PC_JMP;
        OP_BEQ:  w_pcsrc = w_eq ? PC_BR : PC_SEQ;
        OP_BNE:  w_pcsrc = w_eq ? PC_SEQ : PC_BR;
        default: w_pcsrc = PC_SEQ;
      endcase
    end
  end

  assign PCSrcD = w_pcsrc;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage: directed scenarios followed
//            by randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic        clkD = 1'b0;
  logic        rstD, stallD, ForwardAD, ForwardBD, RegWriteW;
  logic [31:0] instrF, PCPlus4F, ALUOutM, ResultW;
  logic [4:0]  WriteRegW;
  logic [31:0] instrD, PCPlus4D, RD1D, RD2D, SignImmD, PCBranchD, PCJumpD;
  logic        validD;
  logic [4:0]  RsD, RtD, RdD;
  logic [1:0]  PCSrcD;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_regs [32];
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;

  decode_stage dut (
    .clkD      (clkD),
    .rstD      (rstD),
    .instrF    (instrF),
    .PCPlus4F  (PCPlus4F),
    .stallD    (stallD),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .ALUOutM   (ALUOutM),
    .RegWriteW (RegWriteW),
    .WriteRegW (WriteRegW),
    .ResultW   (ResultW),
    .instrD    (instrD),
    .PCPlus4D  (PCPlus4D),
    .validD    (validD),
    .RD1D      (RD1D),
    .RD2D      (RD2D),
    .SignImmD  (SignImmD),
    .RsD       (RsD),
    .RtD       (RtD),
    .RdD       (RdD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .PCJumpD   (PCJumpD)
  );

  always #5 clkD = ~clkD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Register read as seen in the current cycle, including write-through
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && WriteRegW == a) return ResultW;
    return m_regs[a];
  endfunction

  function automatic logic [1:0] exp_pcsrc();
    logic [31:0] a, b;
    int op;
    if (!m_valid || stallD || rstD) return 2'b00;
    op = int'(m_instr[31:26]);
    a  = ForwardAD ? ALUOutM : exp_rd(m_instr[25:21]);
    b  = ForwardBD ? ALUOutM : exp_rd(m_instr[20:16]);
    if (op == 2) return 2'b10;
    if (op == 4 && a == b) return 2'b01;
    if (op == 5 && a != b) return 2'b01;
    return 2'b00;
  endfunction

  task automatic compare_all();
    logic signed [31:0] simm;
    simm = $signed(m_instr[15:0]);
    check("instrD",    instrD,   m_instr);
    check("PCPlus4D",  PCPlus4D, m_pc4);
    check("validD",    {31'd0, validD}, {31'd0, m_valid});
    check("RD1D",      RD1D, exp_rd(m_instr[25:21]));
    check("RD2D",      RD2D, exp_rd(m_instr[20:16]));
    check("SignImmD",  SignImmD, simm);
    check("RsRtRd",    {17'd0, RsD, RtD, RdD}, {17'd0, m_instr[25:11]});
    check("PCSrcD",    {30'd0, PCSrcD}, {30'd0, exp_pcsrc()});
    check("PCBranchD", PCBranchD, m_pc4 + simm * 4);
    check("PCJumpD",   PCJumpD, (m_pc4 & 32'hF000_0000) + (32'(m_instr[25:0]) * 4));
  endtask

  task automatic model_update(input logic [1:0] sel);
    if (rstD) begin
      m_instr = 32'd0;
      m_pc4   = 32'd0;
      m_valid = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      if (RegWriteW && WriteRegW != 5'd0) m_regs[WriteRegW] = ResultW;
      if (!stallD) begin
        m_pc4 = PCPlus4F;
        if (sel != 2'b00) begin
          m_instr = 32'd0;
          m_valid = 1'b0;
        end else begin
          m_instr = instrF;
          m_valid = 1'b1;
        end
      end
    end
  endtask

  // Compare the settled cycle, then advance DUT and model together
  task automatic tick();
    logic [1:0] sel;
    #2;
    compare_all();
    sel = exp_pcsrc();
    @(posedge clkD);
    model_update(sel);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic st,
                       input logic fa, input logic fb, input logic [31:0] alu,
                       input logic we, input logic [4:0] wr, input logic [31:0] res,
                       input logic rst);
    instrF    = ins;
    PCPlus4F  = pc;
    stallD    = st;
    ForwardAD = fa;
    ForwardBD = fb;
    ALUOutM   = alu;
    RegWriteW = we;
    WriteRegW = wr;
    ResultW   = res;
    rstD      = rst;
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] ins;

    // Bring both DUT and model to a known state
    drive(32'h8C01_0004, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clkD);
    model_update(2'b00);
    #1;

    // Reset held two cycles with a live fetch
    drive(32'h8C01_0004, 32'h40, 0, 0, 0, 0, 1, 5'd3, 32'h55, 1);
    tick();
    tick();
    drive(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst_instrD", instrD, 32'h0);
    check("rst_validD", {31'd0, validD}, 32'd0);
    check("rst_PCSrcD", {30'd0, PCSrcD}, 32'd0);

    // Every register reads zero after reset
    for (int i = 0; i < 32; i++) begin
      drive({6'd0, 5'(i), 5'd0, 16'd0}, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      #2;
      check("rst_RD1D", RD1D, 32'h0);
    end

    // Write-through bypass into rs=5
    drive({6'd0, 5'd5, 5'd0, 16'd0}, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(32'h0, 32'hC, 0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 0);
    #2;
    check("bypass_RD1D", RD1D, 32'hDEAD_BEEF);
    tick();
    drive(32'h0, 32'h10, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0);
    #2;
    check("r0_RD1D", RD1D, 32'h0);
    tick();

    // beq taken: $1 = $2 = 7
    drive(32'h0, 32'h14, 0, 0, 0, 0, 1, 5'd1, 32'd7, 0);
    tick();
    drive(32'h1022_0003, 32'h100, 0, 0, 0, 0, 1, 5'd2, 32'd7, 0);
    tick();
    drive(32'h2008_0001, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("beq_PCSrcD", {30'd0, PCSrcD}, 32'd1);
    check("beq_PCBranchD", PCBranchD, 32'h10C);
    tick();
    #2;
    check("beq_bubble_instr", instrD, 32'h0);
    check("beq_bubble_valid", {31'd0, validD}, 32'd0);

    // bne with forwarded rt and a negative offset wrapping below zero
    drive(32'h1422_FFFE, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(32'h0, 32'h8, 0, 0, 1, 32'd9, 0, 0, 0, 0);
    #2;
    check("bne_RD1D", RD1D, 32'd7);
    check("bne_PCSrcD", {30'd0, PCSrcD}, 32'd1);
    check("bne_PCBranchD", PCBranchD, 32'hFFFF_FFFC);
    tick();

    // Jump plus its single bubble
    drive(32'h0800_0040, 32'hA000_0010, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(32'h2008_0001, 32'hA000_0014, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("j_PCSrcD", {30'd0, PCSrcD}, 32'd2);
    check("j_PCJumpD", PCJumpD, 32'hA000_0100);
    tick();
    #2;
    check("j_bubble_valid", {31'd0, validD}, 32'd0);

    // Stall over a taken beq, then release
    drive(32'h1022_0003, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h2008_0001, 32'h204 + 32'(i), 1, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("stall_PCSrcD", {30'd0, PCSrcD}, 32'd0);
      check("stall_instrD", instrD, 32'h1022_0003);
      check("stall_PCPlus4D", PCPlus4D, 32'h200);
      tick();
    end
    drive(32'h2008_0001, 32'h204, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("release_PCSrcD", {30'd0, PCSrcD}, 32'd1);
    tick();
    #2;
    check("release_bubble_instr", instrD, 32'h0);
    check("release_bubble_valid", {31'd0, validD}, 32'd0);

    // Randomized traffic with narrow register/data ranges to provoke equality
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 3))
        0:       op = 6'b000010;
        1:       op = 6'b000100;
        2:       op = 6'b000101;
        default: op = 6'($urandom);
      endcase
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      drive(ins, $urandom, $urandom_range(0, 3) == 0,
            1'($urandom), 1'($urandom), 32'($urandom_range(0, 3)),
            1'($urandom), ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)),
            32'($urandom_range(0, 3)), $urandom_range(0, 49) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
